simm_controller: RTL and testbench

- FPM DRAM controller for one 72-pin, 32-bit, double-sided SIMM behind the MAXI030 core bus.
- Sequences RAS/CAS for CPU reads and writes with per-byte-lane CAS.
- Drives the row/column address mux select.
- Holds the CPU in wait states until data is valid or written.
- Performs periodic CAS-before-RAS refresh autonomously.

---
 rtl/simm_controller.sv | 170 +++++++++++++++++
 tb/tb_simm_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/simm_controller.sv
// simm_controller: FPM DRAM controller for one double-sided 32-bit 72-pin SIMM.
// It sequences RAS/CAS with per-lane CAS for CPU reads and writes and drives
// the row/column address mux. It holds the CPU in wait states until the cycle
// completes. It also runs periodic CAS-before-RAS refresh on its own.
// Every output is a register loaded from the state decode, so each strobe
// appears one clock after the state that requests it.
module simm_controller #(
  parameter int REFRESH_INTERVAL = 780,  // clocks between refresh requests
  parameter int CAS_CYCLES       = 2,    // clocks CAS is held before acknowledge
  parameter int REF_RAS_CYCLES   = 3,    // clocks RAS is held during refresh
  parameter int PRECHARGE_CYCLES = 2     // high clocks after any cycle
) (
  input  logic       clock,
  input  logic       reset,         // asynchronous, active low
  input  logic       cs,
  input  logic       read,
  input  logic       write,
  input  logic       bank_addr,
  input  logic [3:0] byte_selects,
  output logic [3:0] ras,
  output logic [3:0] cas,
  output logic       waitstate,
  output logic       mux_select
);

  localparam int RW = $clog2(REFRESH_INTERVAL);

  // Encoding is fixed so the state can be read back as a plain number.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ROW     = 4'd1,
    COL     = 4'd2,
    CAS     = 4'd3,
    ACK     = 4'd4,
    END     = 4'd5,
    PRE     = 4'd6,
    REF_CAS = 4'd7,
    REF_RAS = 4'd8,
    REF_PRE = 4'd9
  } state_t;

  state_t        state;
  logic [15:0]   cnt_q;        // dwell counter for multi-clock states
  logic [RW-1:0] ref_cnt_q;    // free-running refresh interval timer
  logic          ref_wrap;
  logic          pend_q;       // refresh requested, not yet started
  logic          bank_q;       // side latched at the start of an access
  logic [3:0]    lanes_q;      // byte lanes latched at the start of an access
  logic [3:0]    bank_ras;
  logic [3:0]    ras_q;
  logic [3:0]    cas_q;
  logic          wait_q;
  logic          mux_q;

  assign ref_wrap = (ref_cnt_q == RW'(REFRESH_INTERVAL - 1));
  // Bank 0 drives RAS0/RAS2 and bank 1 drives RAS1/RAS3 (active low).
  assign bank_ras = bank_q ? 4'b0101 : 4'b1010;

  assign ras        = ras_q;
  assign cas        = cas_q;
  assign waitstate  = wait_q;
  assign mux_select = mux_q;

  // Refresh interval timer: counts 0..REFRESH_INTERVAL-1 and wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ref_cnt_q <= '0;
    end else if (ref_wrap) begin
      ref_cnt_q <= '0;
    end else begin
      ref_cnt_q <= ref_cnt_q + 1'b1;
    end
  end

  // Main sequencer: state, dwell count, access latches, pending refresh and
  // the registered strobe outputs decoded from the current state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      bank_q  <= 1'b0;
      lanes_q <= 4'b0000;
      ras_q   <= 4'b1111;
      cas_q   <= 4'b1111;
      wait_q  <= 1'b1;
      mux_q   <= 1'b0;
    end else begin
      // A wrap that coincides with the start of a refresh still counts as a
      // new request, so the set has priority over the clear.
      if (state == IDLE && pend_q) pend_q <= 1'b0;
      if (ref_wrap) pend_q <= 1'b1;

      ras_q  <= 4'b1111;
      cas_q  <= 4'b1111;
      wait_q <= 1'b1;
      mux_q  <= 1'b0;

      case (state)
        IDLE: begin
          if (pend_q) begin
            state <= REF_CAS;
          end else if (cs && (read || write)) begin
            // Read and write use the same strobe sequence. Only the side and
            // the lanes must be held for the rest of the cycle.
            state   <= ROW;
            bank_q  <= bank_addr;
            lanes_q <= byte_selects;
          end
        end
        ROW: begin
          ras_q <= bank_ras;
          state <= COL;
        end
        COL: begin
          ras_q <= bank_ras;
          mux_q <= 1'b1;
          cnt_q <= 16'(CAS_CYCLES - 1);
          state <= CAS;
        end
        CAS: begin
          ras_q <= bank_ras;
          mux_q <= 1'b1;
          cas_q <= ~lanes_q;
          if (cnt_q == '0) state <= ACK;
          else             cnt_q <= cnt_q - 1'b1;
        end
        ACK: begin
          ras_q  <= bank_ras;
          mux_q  <= 1'b1;
          cas_q  <= ~lanes_q;
          wait_q <= 1'b0;
          state  <= END;
        end
        END: begin
          // Hold here until cs drops so a held select cannot retrigger.
          if (!cs) begin
            cnt_q <= 16'(PRECHARGE_CYCLES - 1);
            state <= PRE;
          end
        end
        PRE: begin
          if (cnt_q == '0) state <= IDLE;
          else             cnt_q <= cnt_q - 1'b1;
        end
        REF_CAS: begin
          cas_q <= 4'b0000;
          cnt_q <= 16'(REF_RAS_CYCLES - 1);
          state <= REF_RAS;
        end
        REF_RAS: begin
          ras_q <= 4'b0000;
          cas_q <= 4'b0000;
          if (cnt_q == '0) begin
            cnt_q <= 16'(PRECHARGE_CYCLES - 1);
            state <= REF_PRE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        REF_PRE: begin
          if (cnt_q == '0) state <= IDLE;
          else             cnt_q <= cnt_q - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simm_controller.sv
// tb_simm_controller: directed bench for simm_controller with default
// parameters. Time is tracked as cyc, which counts rising edges since reset
// release. A refresh request therefore becomes pending after edge 780*m.
module tb_simm_controller;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ROW     = 4'd1;
  localparam logic [3:0] S_CAS     = 4'd3;
  localparam logic [3:0] S_END     = 4'd5;
  localparam logic [3:0] S_PRE     = 4'd6;
  localparam logic [3:0] S_REF_CAS = 4'd7;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic       bank_addr = 1'b0;
  logic [3:0] byte_selects = 4'b0000;
  logic [3:0] ras;
  logic [3:0] cas;
  logic       waitstate;
  logic       mux_select;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  simm_controller dut (
    .clock        (clock),
    .reset        (reset),
    .cs           (cs),
    .read         (read),
    .write        (write),
    .bank_addr    (bank_addr),
    .byte_selects (byte_selects),
    .ras          (ras),
    .cas          (cas),
    .waitstate    (waitstate),
    .mux_select   (mux_select)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Compare {ras, cas, waitstate, mux_select} against the expected bits.
  task automatic outs(input string tag, input logic [3:0] r, input logic [3:0] c,
                      input logic w, input logic m);
    logic [9:0] obs;
    logic [9:0] exp;
    obs = {ras, cas, waitstate, mux_select};
    exp = {r, c, w, m};
    checks++;
    $display("cyc %0d %s ras=%b cas=%b wait=%b mux=%b", cyc, tag, ras, cas, waitstate, mux_select);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d observed ras/cas/wait/mux=%b required=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = dut.state;
    checks++;
    $display("cyc %0d %s state=%0d", cyc, tag, obs);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d observed state=%0d required=%0d", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    // Reset held low for 10 clocks.
    repeat (10) step();
    outs("in_reset", 4'b1111, 4'b1111, 1'b1, 1'b0);
    st("in_reset", S_IDLE);
    reset = 1'b1;
    cyc = 0;
    repeat (3) step();
    outs("idle", 4'b1111, 4'b1111, 1'b1, 1'b0);
    st("idle", S_IDLE);

    // Read on bank 0, lanes 0 and 1; the request is sampled at edge 4.
    cs = 1'b1; read = 1'b1; bank_addr = 1'b0; byte_selects = 4'b0011;
    step(); st("rd_row", S_ROW); outs("rd_k", 4'b1111, 4'b1111, 1'b1, 1'b0);
    step(); outs("rd_ras", 4'b1010, 4'b1111, 1'b1, 1'b0);
    step(); outs("rd_mux", 4'b1010, 4'b1111, 1'b1, 1'b1);
    step(); outs("rd_cas1", 4'b1010, 4'b1100, 1'b1, 1'b1);
    step(); outs("rd_cas2", 4'b1010, 4'b1100, 1'b1, 1'b1);
    step(); outs("rd_ack", 4'b1010, 4'b1100, 1'b0, 1'b1);
    step(); outs("rd_end", 4'b1111, 4'b1111, 1'b1, 1'b0); st("rd_end", S_END);
    cs = 1'b0; read = 1'b0;
    step(); st("rd_pre1", S_PRE);
    step(); st("rd_pre2", S_PRE);
    step(); st("rd_idle", S_IDLE); outs("rd_idle", 4'b1111, 4'b1111, 1'b1, 1'b0);

    // Write on bank 1, lane 3. The inputs change after the request edge and
    // must be ignored.
    cs = 1'b1; write = 1'b1; bank_addr = 1'b1; byte_selects = 4'b1000;
    step(); st("wr_row", S_ROW);
    bank_addr = 1'b0; byte_selects = 4'b0001;
    step(); outs("wr_ras", 4'b0101, 4'b1111, 1'b1, 1'b0);
    step(); outs("wr_mux", 4'b0101, 4'b1111, 1'b1, 1'b1);
    step(); outs("wr_cas1", 4'b0101, 4'b0111, 1'b1, 1'b1);
    step(); outs("wr_cas2", 4'b0101, 4'b0111, 1'b1, 1'b1);
    step(); outs("wr_ack", 4'b0101, 4'b0111, 1'b0, 1'b1);
    step(); outs("wr_end", 4'b1111, 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step();
      st("wr_hold", S_END);
      outs("wr_hold", 4'b1111, 4'b1111, 1'b1, 1'b0);
    end
    cs = 1'b0; write = 1'b0;
    step(); st("wr_pre1", S_PRE);
    step(); step(); st("wr_idle", S_IDLE);

    // The request goes up on the same clock that the first refresh becomes
    // pending. The refresh runs first and the read follows it.
    while (cyc < 780) step();
    cs = 1'b1; read = 1'b1; bank_addr = 1'b0; byte_selects = 4'b1111;
    step(); st("rq_refcas", S_REF_CAS); outs("rq_k", 4'b1111, 4'b1111, 1'b1, 1'b0);
    step(); outs("rq_refcas", 4'b1111, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); outs("rq_refras", 4'b0000, 4'b0000, 1'b1, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      step(); outs("rq_refpre", 4'b1111, 4'b1111, 1'b1, 1'b0);
    end
    step(); st("rq_row", S_ROW); outs("rq_row", 4'b1111, 4'b1111, 1'b1, 1'b0);
    step(); outs("rq_ras", 4'b1010, 4'b1111, 1'b1, 1'b0);
    step(); outs("rq_mux", 4'b1010, 4'b1111, 1'b1, 1'b1);
    step(); outs("rq_cas1", 4'b1010, 4'b0000, 1'b1, 1'b1);
    step(); outs("rq_cas2", 4'b1010, 4'b0000, 1'b1, 1'b1);
    step(); outs("rq_ack", 4'b1010, 4'b0000, 1'b0, 1'b1);
    step(); st("rq_end", S_END);
    cs = 1'b0; read = 1'b0;

    // Idle refreshes: cas drops at edge 780*m+2, ras follows for 3 clocks,
    // and then come 2 high clocks.
    for (int m = 2; m <= 4; m++) begin
      while (cyc < 780 * m + 1) step();
      outs("ref_before", 4'b1111, 4'b1111, 1'b1, 1'b0);
      step(); outs("ref_cas", 4'b1111, 4'b0000, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        step(); outs("ref_ras", 4'b0000, 4'b0000, 1'b1, 1'b0);
      end
      for (int i = 0; i < 2; i++) begin
        step(); outs("ref_pre", 4'b1111, 4'b1111, 1'b1, 1'b0);
      end
    end

    // Reset while in CAS state aborts the cycle at once.
    cs = 1'b1; read = 1'b1; bank_addr = 1'b1; byte_selects = 4'b0110;
    step(); step(); step(); step();
    st("ab_cas", S_CAS);
    outs("ab_cas", 4'b0101, 4'b1001, 1'b1, 1'b1);
    reset = 1'b0;
    #1;
    outs("ab_reset", 4'b1111, 4'b1111, 1'b1, 1'b0);
    st("ab_reset", S_IDLE);
    cs = 1'b0; read = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    st("ab_idle", S_IDLE);
    outs("ab_idle", 4'b1111, 4'b1111, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
